// File: rtl/mem_dump_reader_pkg.sv
// ---------------------------------------------------------------------------
// mem_dump_reader_pkg
// Shared debug-unit definitions used by the memory dump reader and the
// CPU load/store path.
//   - STATE_W / ST_* : dump FSM state encoding (legacy-style localparams)
//   - MEM_SIZE_WORD  : data-memory access-size code for a 32-bit word
//   - BYTE_WIDTH     : width of one streamed byte
//   - CHKSUM_WIDTH   : width of the optional XOR checksum byte
// ---------------------------------------------------------------------------
package mem_dump_reader_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_READ   = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND   = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHKSUM = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

    localparam int BYTE_WIDTH   = 8;
    localparam int CHKSUM_WIDTH = BYTE_WIDTH;

endpackage

// File: rtl/mem_dump_reader_byte_serializer.sv
// ---------------------------------------------------------------------------
// mem_dump_reader_byte_serializer
// Holds one 32-bit memory word and presents it little-endian, one byte at a
// time, over a valid/ready handshake.
// Ports:
//   clk, i_rst_n      : clock, asynchronous active-low reset
//   i_load            : capture i_word and restart at byte 0
//   i_word            : word read from data memory
//   i_send            : the owning FSM is in its byte-sending state
//   i_tx_ready        : transmitter accepts the presented byte
//   o_tx_data         : currently presented byte
//   o_tx_valid        : byte valid (follows i_send, never i_tx_ready)
//   o_last_accepted   : byte 3 of the word was just accepted
// ---------------------------------------------------------------------------
module mem_dump_reader_byte_serializer
    import mem_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [31:0]           i_word,
    input  logic                  i_send,
    input  logic                  i_tx_ready,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_last_accepted
);

    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        accept;

    assign accept          = i_send & i_tx_ready;
    assign o_tx_valid      = i_send;
    assign o_last_accepted = accept & (byte_idx_q == 2'd3);

    // Byte select straight from registers, so the data only moves when the
    // byte index advances on an accepted transfer.
    assign o_tx_data = word_q[{byte_idx_q, 3'b000} +: BYTE_WIDTH];

    // A new word restarts the byte index; otherwise each accepted byte steps
    // it, wrapping back to 0 after byte 3.
    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        if (i_load) begin
            word_d     = i_word;
            byte_idx_d = 2'd0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    // Word and byte-index registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q     <= 32'h0;
            byte_idx_q <= 2'd0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader
// Debug-unit read initiator: walks a contiguous range of data memory one word
// at a time and streams each word little-endian, byte by byte, to the debug
// UART transmitter. Only the memory read port is driven.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte
// of everything transmitted before finishing.
// Parameters:
//   ADDR_WIDTH   : byte-address width of data memory
// Ports:
//   clk, i_rst_n : clock, asynchronous active-low reset
//   i_start      : one-cycle dump request, honoured only when idle
//   i_base_addr  : byte address of the first word (latched on start)
//   i_word_count : number of words to dump (latched on start)
//   o_mem_raddr  : memory read address (base + 4*index, wraps)
//   o_mem_size   : access size, always word
//   o_mem_ren    : memory read enable
//   i_mem_dout   : memory read data
//   o_tx_data    : byte to transmitter
//   o_tx_valid   : byte valid
//   i_tx_ready   : transmitter accepts byte
//   o_busy       : dump in progress
//   o_done       : one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-2:0] i_word_count,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic [1:0]            o_mem_size,
    output logic                  o_mem_ren,
    input  logic [31:0]           i_mem_dout,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    // State entered once the last data byte has gone out.
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam logic [STATE_W-1:0] ST_FINISH = ST_CHKSUM;
`else
    localparam logic [STATE_W-1:0] ST_FINISH = ST_DONE;
`endif

    localparam logic [ADDR_WIDTH-2:0] IDX_ONE = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

    logic [STATE_W-1:0]    state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-2:0] count_q, count_d;
    logic [ADDR_WIDTH-2:0] index_q, index_d;
    logic [ADDR_WIDTH-2:0] index_next;

    logic                  ser_send;
    logic                  ser_load;
    logic                  ser_last;
    logic                  ser_valid;
    logic [BYTE_WIDTH-1:0] ser_data;

    assign index_next = index_q + IDX_ONE;
    assign ser_send   = (state_q == ST_SEND);
    assign ser_load   = (state_q == ST_WAIT);

    // The top index bit only contributes above bit ADDR_WIDTH-1 once shifted,
    // so dropping it gives the modulo-2^ADDR_WIDTH wrap for free.
    assign o_mem_raddr = base_q + {index_q[ADDR_WIDTH-3:0], 2'b00};
    assign o_mem_size  = MEM_SIZE_WORD;
    // Enable is held through WAIT because the memory gates its output with it.
    assign o_mem_ren   = (state_q == ST_READ) || (state_q == ST_WAIT);
    assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done      = (state_q == ST_DONE);

    mem_dump_reader_byte_serializer u_byte_serializer (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .i_load          (ser_load),
        .i_word          (i_mem_dout),
        .i_send          (ser_send),
        .i_tx_ready      (i_tx_ready),
        .o_tx_data       (ser_data),
        .o_tx_valid      (ser_valid),
        .o_last_accepted (ser_last)
    );

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [CHKSUM_WIDTH-1:0] chk_q, chk_d;

    // Running XOR of every accepted data byte, cleared on each start so a
    // zero-length dump reports 0x00.
    always_comb begin
        chk_d = chk_q;
        if ((state_q == ST_IDLE) && i_start) begin
            chk_d = '0;
        end else if (ser_send && i_tx_ready) begin
            chk_d = chk_q ^ ser_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign o_tx_data  = (state_q == ST_CHKSUM) ? chk_q : ser_data;
    assign o_tx_valid = ser_valid | (state_q == ST_CHKSUM);
`else
    assign o_tx_data  = ser_data;
    assign o_tx_valid = ser_valid;
`endif

    // Dump sequencing: one READ/WAIT pair per word, then SEND until the
    // serializer reports the word's last byte accepted.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        index_d = index_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    count_d = i_word_count;
                    index_d = '0;
                    state_d = (i_word_count == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_SEND;
            ST_SEND: begin
                if (ser_last) begin
                    index_d = index_next;
                    state_d = (index_next == count_q) ? ST_FINISH : ST_READ;
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_CHKSUM: begin
                if (i_tx_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and dump-range registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            index_q <= index_d;
        end
    end

endmodule
